// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: parity modes, FSM encoding
// and the parity-error helper.
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } rx_state_e;

  // The XOR of data and parity bit must equal 1 for odd and 0 for even parity.
  function automatic logic parity_err(input logic xor_data, input logic par_bit,
                                      input int mode);
    logic expected;
    expected = (mode == PAR_ODD) ? 1'b1 : ((mode == PAR_EVEN) ? 1'b0 : 1'b0);
    return (xor_data ^ par_bit) != expected;
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Small first-word-fall-through FIFO holding received words with their flags.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module uart_rx_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4
) (
  input  logic             quick_clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             do_pop;
  logic             do_push;

  // Pointers carry an extra wrap bit so full and empty are distinguishable.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign dout  = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    mem_d    = mem_q;
    if (do_push) begin
      mem_d[wr_ptr_q[AW-1:0]] = din;
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
  end

  always_ff @(posedge quick_clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: rtl/uart_rx_param.sv
// Oversampling UART receiver: synchroniser, start-glitch rejection, mid-bit
// sampling, optional parity, stop-bit check and a receive FIFO.
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 reset,
  input  logic                 quick_clk,
  input  logic                 uart_rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 rx_parity_err,
  output logic                 rx_frame_err,
  output logic                 rx_overrun,
  output logic                 rx_done,
  output logic                 rx_busy
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS);
  localparam int FW = DATA_BITS + 2;
  localparam logic [CW-1:0] HALF_M1  = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] FULL_M1  = CW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

  logic                 sync1_q, sync1_d;
  logic                 sync2_q, sync2_d;
  logic                 prev_q, prev_d;
  rx_state_e            state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [BW-1:0]        bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 perr_q, perr_d;

  logic          rx_s;
  logic          start_edge;
  logic          push;
  logic          ferr;
  logic          fifo_full;
  logic          fifo_empty;
  logic          pop;
  logic [FW-1:0] fifo_din;
  logic [FW-1:0] fifo_dout;

  assign rx_s       = sync2_q;
  assign start_edge = !rx_s && prev_q;

  always_comb begin
    sync1_d   = uart_rx;
    sync2_d   = sync1_q;
    prev_d    = sync2_q;
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    perr_d    = perr_q;
    push      = 1'b0;
    ferr      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // Only a high-to-low transition starts a frame; a held-low line does not.
        if (start_edge) begin
          cnt_d   = '0;
          state_d = ST_START;
        end
      end
      ST_START: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == HALF_M1) begin
          cnt_d = '0;
          if (rx_s) begin
            state_d = ST_IDLE;
          end else begin
            bit_idx_d = '0;
            perr_d    = 1'b0;
            state_d   = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == FULL_M1) begin
          cnt_d     = '0;
          // LSB first: after DATA_BITS shifts the first bit sits at bit 0.
          shift_d   = {rx_s, shift_q[DATA_BITS-1:1]};
          bit_idx_d = bit_idx_q + BW'(1);
          if (bit_idx_q == LAST_BIT) begin
            state_d = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
          end
        end
      end
      ST_PARITY: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == FULL_M1) begin
          cnt_d   = '0;
          perr_d  = parity_err(^shift_q, rx_s, PARITY);
          state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == FULL_M1) begin
          cnt_d   = '0;
          ferr    = ~rx_s;
          push    = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge quick_clk or negedge reset) begin
    if (!reset) begin
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      prev_q    <= 1'b1;
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      perr_q    <= 1'b0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      prev_q    <= prev_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      perr_q    <= perr_d;
    end
  end

  assign fifo_din = {perr_q, ferr, shift_q};
  assign pop      = rx_valid && rx_ready;

  uart_rx_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .quick_clk (quick_clk),
    .reset     (reset),
    .push      (push),
    .din       (fifo_din),
    .full      (fifo_full),
    .pop       (pop),
    .dout      (fifo_dout),
    .empty     (fifo_empty)
  );

  // Valid/ready: the head word and its flags hold while rx_valid && !rx_ready;
  // a word leaves the FIFO at the clock edge where both are high.
  assign rx_valid      = !fifo_empty;
  assign rx_data       = fifo_dout[DATA_BITS-1:0];
  assign rx_frame_err  = fifo_dout[DATA_BITS];
  assign rx_parity_err = fifo_dout[DATA_BITS+1];
  assign rx_overrun    = push && fifo_full && !pop;
  assign rx_done       = push;
  assign rx_busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed bench for uart_rx_param: one instance without parity, one with
// even parity, each on its own serial line.
module tb_uart_rx_param;

  localparam int OS = 16;

  logic quick_clk = 1'b0;
  logic reset     = 1'b0;
  logic uart_rx_a = 1'b1;
  logic uart_rx_b = 1'b1;
  logic rx_ready  = 1'b1;

  logic [7:0] rx_data_a, rx_data_b;
  logic rx_valid_a, rx_parity_err_a, rx_frame_err_a, rx_overrun_a, rx_done_a, rx_busy_a;
  logic rx_valid_b, rx_parity_err_b, rx_frame_err_b, rx_overrun_b, rx_done_b, rx_busy_b;

  always #5 quick_clk = ~quick_clk;

  uart_rx_param #(.OVERSAMPLE(OS), .DATA_BITS(8), .PARITY(0), .FIFO_DEPTH(4)) dut_a (
    .reset(reset), .quick_clk(quick_clk), .uart_rx(uart_rx_a),
    .rx_data(rx_data_a), .rx_valid(rx_valid_a), .rx_ready(rx_ready),
    .rx_parity_err(rx_parity_err_a), .rx_frame_err(rx_frame_err_a),
    .rx_overrun(rx_overrun_a), .rx_done(rx_done_a), .rx_busy(rx_busy_a)
  );

  uart_rx_param #(.OVERSAMPLE(OS), .DATA_BITS(8), .PARITY(2), .FIFO_DEPTH(4)) dut_b (
    .reset(reset), .quick_clk(quick_clk), .uart_rx(uart_rx_b),
    .rx_data(rx_data_b), .rx_valid(rx_valid_b), .rx_ready(rx_ready),
    .rx_parity_err(rx_parity_err_b), .rx_frame_err(rx_frame_err_b),
    .rx_overrun(rx_overrun_b), .rx_done(rx_done_b), .rx_busy(rx_busy_b)
  );

  // Scoreboard: words are {parity_err, frame_err, data}.
  logic [9:0] exp_q[$];
  logic [9:0] got_a_q[$];
  logic [9:0] got_b_q[$];
  int done_a = 0, done_b = 0, ovr_a = 0;
  int n_cmp = 0, n_bad = 0;

  always @(negedge quick_clk) begin
    if (reset) begin
      if (rx_done_a) done_a++;
      if (rx_done_b) done_b++;
      if (rx_overrun_a) ovr_a++;
      if (rx_valid_a && rx_ready) got_a_q.push_back({rx_parity_err_a, rx_frame_err_a, rx_data_a});
      if (rx_valid_b && rx_ready) got_b_q.push_back({rx_parity_err_b, rx_frame_err_b, rx_data_b});
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge quick_clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic drive_line(input int sel, input logic v);
    if (sel == 0) uart_rx_a = v;
    else          uart_rx_b = v;
  endtask

  task automatic send_frame(input int sel, input logic [7:0] d, input logic par_en,
                            input logic par_bit, input logic stop_bit);
    drive_line(sel, 1'b0);
    idle(OS);
    for (int i = 0; i < 8; i++) begin
      drive_line(sel, d[i]);
      idle(OS);
    end
    if (par_en) begin
      drive_line(sel, par_bit);
      idle(OS);
    end
    drive_line(sel, stop_bit);
    idle(OS);
  endtask

  typedef struct {
    int         sel;
    logic [7:0] d;
    logic       par_bit;
    logic [9:0] exp;
  } vec_t;

  vec_t vecs[8];
  int   lat;
  bit   seen;
  int   done_base;
  logic [9:0] got_w;

  initial begin
    vecs[0] = '{0, 8'hA5, 1'b0, {2'b00, 8'hA5}};
    vecs[1] = '{0, 8'h00, 1'b0, {2'b00, 8'h00}};
    vecs[2] = '{0, 8'hFF, 1'b0, {2'b00, 8'hFF}};
    vecs[3] = '{0, 8'h3C, 1'b0, {2'b00, 8'h3C}};
    vecs[4] = '{1, 8'h03, 1'b1, {2'b10, 8'h03}};
    vecs[5] = '{1, 8'h03, 1'b0, {2'b00, 8'h03}};
    vecs[6] = '{1, 8'h80, 1'b1, {2'b00, 8'h80}};
    vecs[7] = '{1, 8'h7F, 1'b0, {2'b10, 8'h7F}};

    // Reset state
    idle(3);
    check("reset_outputs_a", {rx_data_a, rx_valid_a, rx_parity_err_a, rx_frame_err_a,
                              rx_overrun_a, rx_done_a, rx_busy_a}, 0);
    check("reset_outputs_b", {rx_data_b, rx_valid_b, rx_parity_err_b, rx_frame_err_b,
                              rx_overrun_b, rx_done_b, rx_busy_b}, 0);
    reset = 1'b1;
    idle(8);

    // Single 0xA5 frame: latency and one-cycle FIFO residency
    done_base = done_a;
    seen = 0;
    lat  = 0;
    fork
      send_frame(0, 8'hA5, 1'b0, 1'b0, 1'b1);
      begin
        for (int k = 1; k <= 300 && !seen; k++) begin
          step();
          if (rx_done_a) begin
            seen = 1;
            lat  = k;
          end
        end
        check("t1_done_seen", seen, 1);
        check("t1_done_latency", (lat >= 152 && lat <= 156), 1);
        step();
        check("t1_valid_after_done", rx_valid_a, 1);
        check("t1_data", rx_data_a, 8'hA5);
        check("t1_flags", {rx_parity_err_a, rx_frame_err_a}, 0);
        step();
        check("t1_valid_fall", rx_valid_a, 0);
      end
    join
    idle(8);
    check("t1_done_once", done_a - done_base, 1);
    got_a_q.delete();

    // Table of frames for both instances
    for (int v = 0; v < 8; v++) begin
      got_a_q.delete();
      got_b_q.delete();
      exp_q.push_back(vecs[v].exp);
      send_frame(vecs[v].sel, vecs[v].d, vecs[v].sel == 1, vecs[v].par_bit, 1'b1);
      idle(16);
      if (vecs[v].sel == 0) begin
        check($sformatf("vec%0d_count", v), got_a_q.size(), 1);
        got_w = (got_a_q.size() > 0) ? got_a_q.pop_front() : 10'h3FF;
      end else begin
        check($sformatf("vec%0d_count", v), got_b_q.size(), 1);
        got_w = (got_b_q.size() > 0) ? got_b_q.pop_front() : 10'h3FF;
      end
      check($sformatf("vec%0d_word", v), got_w, exp_q.pop_front());
    end

    // Start glitch of 4 cycles
    done_base = done_a;
    uart_rx_a = 1'b0;
    idle(4);
    uart_rx_a = 1'b1;
    check("t2_busy_rises", rx_busy_a, 1);
    idle(20);
    check("t2_busy_low", rx_busy_a, 0);
    check("t2_no_done", done_a - done_base, 0);
    check("t2_fifo_empty", rx_valid_a, 0);

    // Stop bit held low, then line stays low (break)
    got_a_q.delete();
    send_frame(0, 8'h55, 1'b0, 1'b0, 1'b0);
    idle(4);
    check("t4_frame_err_word", (got_a_q.size() > 0) ? got_a_q.pop_front() : 10'h3FF,
          {2'b01, 8'h55});
    done_base = done_a;
    idle(64);
    check("t4_break_no_frame", done_a - done_base, 0);
    check("t4_break_not_busy", rx_busy_a, 0);
    uart_rx_a = 1'b1;
    idle(32);
    check("t4_high_no_frame", done_a - done_base, 0);
    got_a_q.delete();
    send_frame(0, 8'h5A, 1'b0, 1'b0, 1'b1);
    idle(8);
    check("t4_recover_word", (got_a_q.size() > 0) ? got_a_q.pop_front() : 10'h3FF,
          {2'b00, 8'h5A});

    // Overrun with a stalled consumer
    rx_ready = 1'b0;
    ovr_a = 0;
    got_a_q.delete();
    send_frame(0, 8'h11, 1'b0, 1'b0, 1'b1); idle(8);
    send_frame(0, 8'h22, 1'b0, 1'b0, 1'b1); idle(8);
    send_frame(0, 8'h33, 1'b0, 1'b0, 1'b1); idle(8);
    send_frame(0, 8'h44, 1'b0, 1'b0, 1'b1); idle(8);
    check("t5_no_overrun_yet", ovr_a, 0);
    check("t5_head_stable", {rx_valid_a, rx_data_a}, {1'b1, 8'h11});
    send_frame(0, 8'h55, 1'b0, 1'b0, 1'b1); idle(8);
    check("t5_overrun_once", ovr_a, 1);
    check("t5_head_after_overrun", rx_data_a, 8'h11);
    rx_ready = 1'b1;
    idle(8);
    check("t5_pop_count", got_a_q.size(), 4);
    for (int i = 0; i < 4; i++) begin
      got_w = (got_a_q.size() > 0) ? got_a_q.pop_front() : 10'h3FF;
      check($sformatf("t5_pop%0d", i), got_w, {2'b00, 8'h11 * (i + 1)});
    end
    check("t5_drained", rx_valid_a, 0);

    // Reset in the middle of data bit 4, with a word already buffered
    rx_ready = 1'b0;
    send_frame(0, 8'h77, 1'b0, 1'b0, 1'b1);
    idle(4);
    check("t6_preload_valid", rx_valid_a, 1);
    fork
      send_frame(0, 8'hF0, 1'b0, 1'b0, 1'b1);
      begin
        idle(88);
        reset = 1'b0;
        step();
        check("t6_outputs_in_reset", {rx_data_a, rx_valid_a, rx_parity_err_a, rx_frame_err_a,
                                      rx_overrun_a, rx_done_a, rx_busy_a}, 0);
      end
    join
    idle(4);
    reset = 1'b1;
    idle(8);
    check("t6_fifo_cleared", rx_valid_a, 0);
    check("t6_idle_after_reset", rx_busy_a, 0);
    rx_ready = 1'b1;
    got_a_q.delete();
    done_base = done_a;
    send_frame(0, 8'h3C, 1'b0, 1'b0, 1'b1);
    idle(16);
    check("t6_one_frame", done_a - done_base, 1);
    check("t6_word_count", got_a_q.size(), 1);
    check("t6_word", (got_a_q.size() > 0) ? got_a_q.pop_front() : 10'h3FF, {2'b00, 8'h3C});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
